// File: rtl/bus_slave_port.sv
// bus_slave_port: bit-serial responder end of the system bus.
// Deserialises an LSB-first address (and, for writes, data) from the master,
// owns a small local register memory, and serialises read data back.
// Optional build macro BUS_SLAVE_PARITY_EN adds an even-parity bit after the
// data bits in both directions and reports bad write parity on s_err.
module bus_slave_port #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic slave_select,
  input  logic m_valid,
  input  logic m_rw,
  input  logic m_dout,
  output logic s_ready,
  output logic s_dout,
  output logic s_dout_valid,
  output logic s_done,
  output logic s_err
);

`ifdef BUS_SLAVE_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int WORD_BITS = DATA_WIDTH + PAR_BITS;
  localparam int MAX_BITS  = ((ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH) + PAR_BITS;
  localparam int CW        = $clog2(MAX_BITS + 1);
  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] WORD_LAST = CW'(WORD_BITS - 1);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RLAT, RDATA, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [WORD_BITS-1:0]   wdata_q, wdata_d;
  logic [WORD_BITS-1:0]   rdata_q, rdata_d;
  logic                   rw_q, rw_d;
  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
  logic                   wr_err;

  // A write whose received word (data plus parity) has odd parity is rejected
`ifdef BUS_SLAVE_PARITY_EN
  assign wr_err = ^wdata_q;
`else
  assign wr_err = 1'b0;
`endif

  // Transaction registers; reset wins over everything, discarding partial work
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rw_q    <= rw_d;
    end
  end

  // Local memory: a write commits on the edge leaving DONE, so a read that
  // follows immediately already sees the new word
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (state_q == DONE && rw_q && !wr_err) begin
      mem_q[addr_q] <= wdata_q[DATA_WIDTH-1:0];
    end
  end

  // Next-state logic: shift in address/data on accepted bits, shift out read
  // data without backpressure, and bail to IDLE whenever the grant drops
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rw_d    = rw_q;
    case (state_q)
      IDLE: begin
        if (slave_select && m_valid) begin
          rw_d    = m_rw;
          cnt_d   = '0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (!slave_select) begin
          state_d = IDLE;
        end else if (m_valid) begin
          addr_d = {m_dout, addr_q[ADDR_WIDTH-1:1]};
          if (cnt_q == ADDR_LAST) begin
            cnt_d   = '0;
            state_d = rw_q ? WDATA : RLAT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WDATA: begin
        if (!slave_select) begin
          state_d = IDLE;
        end else if (m_valid) begin
          wdata_d = {m_dout, wdata_q[WORD_BITS-1:1]};
          if (cnt_q == WORD_LAST) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RLAT: begin
        if (!slave_select) begin
          state_d = IDLE;
        end else begin
`ifdef BUS_SLAVE_PARITY_EN
          rdata_d = {^mem_q[addr_q], mem_q[addr_q]};
`else
          rdata_d = mem_q[addr_q];
`endif
          cnt_d   = '0;
          state_d = RDATA;
        end
      end
      RDATA: begin
        if (!slave_select) begin
          state_d = IDLE;
        end else begin
          rdata_d = rdata_q >> 1;
          if (cnt_q == WORD_LAST) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status and serial outputs decoded from the state register; valid is
  // gated by the grant so it drops in the very cycle the master is deselected
  always_comb begin
    s_ready      = (state_q == IDLE);
    s_dout_valid = (state_q == RDATA) && slave_select;
    s_dout       = s_dout_valid && rdata_q[0];
    s_done       = (state_q == DONE);
    s_err        = (state_q == DONE) && rw_q && wr_err;
  end

endmodule

// File: tb/tb_bus_slave_port.sv
// Directed testbench for bus_slave_port: reset, writes with and without
// stalls, reads, aborts, reset during read data, and parity when
// BUS_SLAVE_PARITY_EN is defined.
module tb_bus_slave_port;

`ifdef BUS_SLAVE_PARITY_EN
  localparam int W = 9;
`else
  localparam int W = 8;
`endif

  logic clk = 1'b0;
  logic reset, slave_select, m_valid, m_rw, m_dout;
  logic s_ready, s_dout, s_dout_valid, s_done, s_err;
  int   passCount = 0;
  int   checkCount = 0;

  bus_slave_port #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .slave_select(slave_select), .m_valid(m_valid),
    .m_rw(m_rw), .m_dout(m_dout), .s_ready(s_ready), .s_dout(s_dout),
    .s_dout_valid(s_dout_valid), .s_done(s_done), .s_err(s_err)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  task automatic start_txn(input logic rw);
    @(negedge clk);
    slave_select = 1'b1;
    m_valid = 1'b1;
    m_rw = rw;
    m_dout = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    m_valid = 1'b1;
    m_dout = b;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    m_valid = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d, input int stallAfter,
                          input int stallLen, input logic par, output logic doneNow,
                          output logic errNow, output logic doneNext);
    start_txn(1'b1);
    for (int i = 0; i < 4; i++) send_bit(a[i]);
    for (int i = 0; i < 8; i++) begin
      if (i == stallAfter) repeat (stallLen) idle_cycle();
      send_bit(d[i]);
    end
`ifdef BUS_SLAVE_PARITY_EN
    send_bit(par);
`else
    if (par) m_dout = 1'b0;
`endif
    idle_cycle();
    #1;
    doneNow = s_done;
    errNow = s_err;
    @(negedge clk);
    #1;
    doneNext = s_done;
  endtask

  task automatic do_read(input logic [3:0] a, output logic [15:0] data, output int nValid,
                         output int first, output logic done, output int badDout);
    start_txn(1'b0);
    for (int i = 0; i < 4; i++) send_bit(a[i]);
    idle_cycle();
    data = '0;
    nValid = 0;
    first = -1;
    done = 1'b0;
    badDout = 0;
    for (int c = 0; c < 24 && !done; c++) begin
      #1;
      if (s_dout_valid) begin
        if (first < 0) first = c;
        if (nValid < 16) data[nValid] = s_dout;
        nValid++;
      end else if (s_dout !== 1'b0) begin
        badDout++;
      end
      if (s_done) done = 1'b1;
      if (!done) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [15:0] d; int n, f, bad; logic dn;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checkCount++;
    if (s_ready !== 1'b1) $display("[TB] FAIL reset_ready got=%b exp=1", s_ready); else passCount++;
    checkCount++;
    if ({s_dout_valid, s_dout, s_done, s_err} !== 4'b0000)
      $display("[TB] FAIL reset_outputs got=%b exp=0000", {s_dout_valid, s_dout, s_done, s_err});
    else passCount++;
    do_read(4'h0, d, n, f, dn, bad);
    checkCount++;
    if (d !== 16'h0000) $display("[TB] FAIL reset_read0 got=%h exp=0000", d); else passCount++;
  endtask

  task automatic test_write_read();
    logic dNow, eNow, dNext, dn; logic [15:0] d; int n, f, bad;
    logic [15:0] expWord;
    do_write(4'h3, 8'b10101010, 99, 0, 1'b0, dNow, eNow, dNext);
    checkCount++;
    if ({dNow, eNow, dNext} !== 3'b100)
      $display("[TB] FAIL write3_done got=%b exp=100", {dNow, eNow, dNext});
    else passCount++;
    do_read(4'h3, d, n, f, dn, bad);
    expWord = (W == 9) ? 16'h00AA : 16'h00AA;
    checkCount++;
    if (d !== expWord) $display("[TB] FAIL read3_data got=%h exp=%h", d, expWord); else passCount++;
    checkCount++;
    if (n !== W) $display("[TB] FAIL read3_nvalid got=%0d exp=%0d", n, W); else passCount++;
    checkCount++;
    if (f !== 1) $display("[TB] FAIL read3_latency got=%0d exp=1", f); else passCount++;
    checkCount++;
    if ({dn, (bad == 0)} !== 2'b11)
      $display("[TB] FAIL read3_done_dout got=done%b bad%0d exp=done1 bad0", dn, bad);
    else passCount++;
  endtask

  task automatic test_stall();
    logic dNow, eNow, dNext, dn; logic [15:0] d; int n, f, bad;
    do_write(4'h5, 8'b01100010, 4, 3, 1'b1, dNow, eNow, dNext);
    checkCount++;
    if ({dNow, dNext} !== 2'b10) $display("[TB] FAIL stall_done got=%b exp=10", {dNow, dNext}); else passCount++;
    do_read(4'h5, d, n, f, dn, bad);
    checkCount++;
    if (d[7:0] !== 8'h62) $display("[TB] FAIL stall_read5 got=%h exp=62", d[7:0]); else passCount++;
  endtask

  task automatic test_abort_write();
    logic sawDone; logic [15:0] d; int n, f, bad; logic dn;
    sawDone = 1'b0;
    start_txn(1'b1);
    for (int i = 0; i < 4; i++) send_bit(i < 3);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    @(negedge clk);
    slave_select = 1'b0;
    m_valid = 1'b0;
    #1;
    checkCount++;
    if (s_ready !== 1'b0) $display("[TB] FAIL abortw_busy got=%b exp=0", s_ready); else passCount++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (s_done) sawDone = 1'b1;
    end
    checkCount++;
    if ({s_ready, sawDone} !== 2'b10)
      $display("[TB] FAIL abortw_idle got=ready%b done%b exp=ready1 done0", s_ready, sawDone);
    else passCount++;
    do_read(4'h7, d, n, f, dn, bad);
    checkCount++;
    if (d !== 16'h0000) $display("[TB] FAIL abortw_read7 got=%h exp=0000", d); else passCount++;
  endtask

  task automatic test_abort_read();
    start_txn(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i == 0 || i == 2);
    idle_cycle();
    repeat (3) @(negedge clk);
    slave_select = 1'b0;
    #1;
    checkCount++;
    if ({s_dout_valid, s_dout} !== 2'b00)
      $display("[TB] FAIL abortr_valid got=%b exp=00", {s_dout_valid, s_dout});
    else passCount++;
    @(negedge clk);
    #1;
    checkCount++;
    if ({s_ready, s_done} !== 2'b10) $display("[TB] FAIL abortr_idle got=%b exp=10", {s_ready, s_done}); else passCount++;
  endtask

  task automatic test_reset_in_rdata();
    logic [15:0] d; int n, f, bad; logic dn;
    start_txn(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i < 2);
    idle_cycle();
    repeat (4) @(negedge clk);
    #1;
    checkCount++;
    if (s_dout_valid !== 1'b1) $display("[TB] FAIL rst_rdata_pre got=%b exp=1", s_dout_valid); else passCount++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkCount++;
    if ({s_dout_valid, s_ready} !== 2'b01)
      $display("[TB] FAIL rst_rdata_post got=%b exp=01", {s_dout_valid, s_ready});
    else passCount++;
    do_read(4'h3, d, n, f, dn, bad);
    checkCount++;
    if (d !== 16'h0000) $display("[TB] FAIL rst_read3 got=%h exp=0000", d); else passCount++;
  endtask

  task automatic test_back_to_back();
    logic dNow, eNow, dNext, dn; logic [15:0] d; int n, f, bad;
    do_write(4'h9, 8'h3C, 99, 0, 1'b0, dNow, eNow, dNext);
    do_read(4'h9, d, n, f, dn, bad);
    checkCount++;
    if (d[7:0] !== 8'h3C) $display("[TB] FAIL b2b_read9 got=%h exp=3c", d[7:0]); else passCount++;
  endtask

`ifdef BUS_SLAVE_PARITY_EN
  task automatic test_parity();
    logic dNow, eNow, dNext, dn; logic [15:0] d; int n, f, bad;
    do_write(4'hB, 8'hAA, 99, 0, 1'b0, dNow, eNow, dNext);
    checkCount++;
    if ({dNow, eNow} !== 2'b10) $display("[TB] FAIL par_good got=%b exp=10", {dNow, eNow}); else passCount++;
    do_read(4'hB, d, n, f, dn, bad);
    checkCount++;
    if (d !== 16'h00AA) $display("[TB] FAIL par_good_read got=%h exp=00aa", d); else passCount++;
    do_write(4'hC, 8'hAA, 99, 0, 1'b1, dNow, eNow, dNext);
    checkCount++;
    if ({dNow, eNow} !== 2'b11) $display("[TB] FAIL par_bad got=%b exp=11", {dNow, eNow}); else passCount++;
    do_read(4'hC, d, n, f, dn, bad);
    checkCount++;
    if (d !== 16'h0000) $display("[TB] FAIL par_bad_read got=%h exp=0000", d); else passCount++;
    do_write(4'hD, 8'h07, 99, 0, 1'b1, dNow, eNow, dNext);
    do_read(4'hD, d, n, f, dn, bad);
    checkCount++;
    if (d !== 16'h0107) $display("[TB] FAIL par_odd_read got=%h exp=0107", d); else passCount++;
  endtask
`endif

  // Sequence every scenario, then report
  initial begin
    reset = 1'b1;
    slave_select = 1'b0;
    m_valid = 1'b0;
    m_rw = 1'b0;
    m_dout = 1'b0;
    test_reset();
    test_write_read();
    test_stall();
    test_abort_write();
    test_abort_read();
    test_reset_in_rdata();
    test_back_to_back();
`ifdef BUS_SLAVE_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
